// File: rtl/seq_mac_multiplier_if.sv
// Operand/result bundle between the SPI register file and the shift-add multiplier.
// Pure wiring: no storage, so it adds no cycles of latency.
// Flow control is start/busy/done; the master must hold off while busy is high.
interface seq_mac_multiplier_if #(
  parameter int width     = 4,
  parameter int ACC_GUARD = 4
);
  logic                          start;
  logic [width-1:0]              A;
  logic [width-1:0]              B;
  logic                          sgn;
  logic                          acc;
  logic                          clr_acc;
  logic [2*width-1:0]            res;
  logic [2*width+ACC_GUARD-1:0]  acc_out;
  logic                          busy;
  logic                          done;

  modport master (
    output start, A, B, sgn, acc, clr_acc,
    input  res, acc_out, busy, done
  );

  modport slave (
    input  start, A, B, sgn, acc, clr_acc,
    output res, acc_out, busy, done
  );
endinterface

// File: rtl/seq_mac_multiplier.sv
// Sequential shift-add multiplier, signed/unsigned, with optional accumulate.
// Latency: done pulses in the cycle after edge t0+width; throughput width+1 cycles.
// Backpressure: start is ignored while busy (no queuing); operands latched on accept.
module seq_mac_multiplier #(
  parameter int width     = 4,
  parameter int ACC_GUARD = 4
) (
  input logic               clk,
  input logic               rst_n,
  seq_mac_multiplier_if.slave bus
);
  localparam int PW = 2 * width;
  localparam int AW = 2 * width + ACC_GUARD;
  localparam int CW = $clog2(width + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [width-1:0] mcand;     // multiplicand magnitude
  logic [PW-1:0]    pp;        // {partial sum, remaining multiplier bits}
  logic [CW-1:0]    cnt;
  logic             neg;       // product must be negated at completion
  logic             sgn_q;
  logic             acc_q;
  logic [PW-1:0]    res_r;
  logic [AW-1:0]    acc_r;
  logic             busy_r;
  logic             done_r;

  logic [width-1:0] a_mag;
  logic [width-1:0] b_mag;
  logic [width:0]   sum;
  logic [PW-1:0]    pp_next;
  logic [PW-1:0]    prod;
  logic [AW-1:0]    prod_ext;
  logic [AW-1:0]    acc_base;

  // Operand magnitudes, one shift-add step, final sign fix-up and accumulator inputs.
  // The most-negative operand negates onto itself, which read as unsigned is its magnitude.
  always_comb begin
    a_mag    = (bus.sgn && bus.A[width-1]) ? -bus.A : bus.A;
    b_mag    = (bus.sgn && bus.B[width-1]) ? -bus.B : bus.B;
    sum      = {1'b0, pp[PW-1:width]} + (pp[0] ? {1'b0, mcand} : '0);
    pp_next  = {sum, pp[width-1:1]};
    prod     = neg ? -pp_next : pp_next;
    prod_ext = sgn_q ? {{ACC_GUARD{prod[PW-1]}}, prod} : {{ACC_GUARD{1'b0}}, prod};
    acc_base = bus.clr_acc ? '0 : acc_r;
  end

  // Control FSM with registered outputs; clr_acc applies first so a coincident
  // accumulating completion lands on a freshly cleared accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mcand  <= '0;
      pp     <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      sgn_q  <= 1'b0;
      acc_q  <= 1'b0;
      res_r  <= '0;
      acc_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      acc_r  <= acc_base;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= a_mag;
            pp     <= {{width{1'b0}}, b_mag};
            cnt    <= CW'(width);
            neg    <= bus.sgn & (bus.A[width-1] ^ bus.B[width-1]);
            sgn_q  <= bus.sgn;
            acc_q  <= bus.acc;
            busy_r <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          pp  <= pp_next;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            res_r  <= prod;
            done_r <= 1'b1;
            busy_r <= 1'b0;
            state  <= IDLE;
            if (acc_q) begin
              acc_r <= acc_base + prod_ext;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.res     = res_r;
  assign bus.acc_out = acc_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
endmodule

// File: doc/seq_mac_multiplier.md
Name: seq_mac_multiplier

Overview:
Parametrised sequential shift-add multiplier. It adds a signed/unsigned operand mode and an optional multiply-accumulate register. It is the successor to the team's fixed unsigned start/done multiplier and keeps the same start/A/B/res/done handshake. It sits behind the SPI peripheral register file, which pulses start and polls busy/done.

Parameters:
width, 4, operand width in bits (>=2)
ACC_GUARD, 4, extra accumulator bits above 2*width to absorb overflow

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  launch request; sampled on rising clk edge in IDLE only
A  input  width  multiplicand; latched when start accepted
B  input  width  multiplier; latched when start accepted
sgn  input  1  1 = A, B two's complement; 0 = unsigned; latched with start
acc  input  1  1 = add product into accumulator on completion; latched with start
clr_acc  input  1  synchronous accumulator clear
res  output  2*width  product of last completed operation
acc_out  output  2*width+ACC_GUARD  accumulator value
busy  output  1  high while an operation is in flight
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; res=0, acc_out=0, busy=0, done=0; counter and internal registers cleared. Reset mid-operation aborts it: no done, res and acc_out forced to 0.
- States: IDLE, RUN.
- IDLE + start=1 at edge t0:
  - latch A, B, sgn, acc;
  - if sgn, latch magnitudes |A|, |B| and neg = A[msb]^B[msb];
  - partial product = 0; counter = width; busy=1 from t0; go to RUN.
- RUN, each edge:
  - if multiplier LSB=1, add multiplicand to upper half of partial product (width+1-bit sum);
  - shift right one bit; counter decrements.
- Completion (edge t0+width, counter reaches 0):
  - res = partial product, or its two's-complement negation if neg;
  - done=1 for exactly one cycle; busy=0; return to IDLE.
- Latency: done is visible in the cycle after edge t0+width. This is fixed regardless of operand values, including zero operands.
- Back-to-back: start is accepted in the cycle where done=1 (state is IDLE). Throughput is one result per width+1 cycles max.
- Ignored inputs: start while busy is ignored, with no queuing. A, B, sgn and acc changes after acceptance are ignored.
- Arithmetic:
  - Unsigned result is exact in 2*width bits.
  - Signed result is exact in 2*width bits, including (-2^(width-1))^2 = 2^(2*width-2).
  - Magnitude of the most-negative value is held in width bits unsigned; this is correct.
- Accumulator:
  - On completion with acc=1, acc_out += res. res is sign-extended if sgn, zero-extended otherwise.
  - The add wraps modulo 2^(2*width+ACC_GUARD).
  - With acc=0, acc_out is unchanged.
- clr_acc=1 at an edge sets acc_out=0.
  - If it coincides with an accumulating completion, acc_out = new extended product (clear then add).
  - clr_acc does not affect res, busy or the state machine.
- res and acc_out hold their values between completions.

Test Plan:
- width=4, sgn=0, A=15, B=15, start at edge t0 -> busy high from t0; done high for exactly one cycle after edge t0+4; res=8'hE1; busy low with done.
- sgn=1: A=4'h8, B=4'h8 -> res=8'h40. A=4'hD (-3), B=4'h5 -> res=8'hF1 (-15). A=4'h7, B=4'h0 -> res=0 with full latency.
- start held high during RUN with different A/B -> single done; result from the first operands. Next start in the done cycle -> accepted, second done 5 cycles later.
- Accumulate with sgn=1, acc=1: 7*7, then -8*7, then 3*3 -> acc_out after each = 49, -7, 2 (12-bit: 12'h031, 12'hFF9, 12'h002). clr_acc coincident with a 2*2 completion -> acc_out=4.
- rst_n pulsed low two cycles after start -> outputs immediately 0, no done pulse; a fresh 3*5 afterwards -> res=15.
- Exhaustive sweep of all 256 A/B pairs, unsigned and signed, width=4 -> res matches reference product every time; repeat sampled sweep at width=8.
